// File: rtl/mux_arbiter.sv
// Two-input round-robin stream merger with a single registered output stage.
// Words from sources a and b are tagged on sel_o (0 = a, 1 = b) so a downstream splitter can re-route them.
module mux_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic             a_valid_i,
    output logic             a_ready_o,
    input  logic [WIDTH-1:0] b_i,
    input  logic             b_valid_i,
    output logic             b_ready_o,
    output logic [WIDTH-1:0] out_o,
    output logic             sel_o,
    output logic             valid_o,
    input  logic             ready_i
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             sel_q, sel_d;
    logic             last_grant_q, last_grant_d;
    logic             load_en;
    logic             grant_a;
    logic             grant_b;

    // Contention goes to whichever source was not granted last.
    always_comb begin
        load_en = !rst_i && ((state_q == EMPTY) || ready_i);
        grant_a = a_valid_i && (!b_valid_i || (last_grant_q == SRC_B));
        grant_b = b_valid_i && (!a_valid_i || (last_grant_q == SRC_A));
    end

    assign a_ready_o = load_en && grant_a;
    assign b_ready_o = load_en && grant_b;

    // NOTE: every next-state signal gets a default hold value first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        if (a_ready_o) begin
            state_d      = FULL;
            data_d       = a_i;
            sel_d        = SRC_A;
            last_grant_d = SRC_A;
        end else if (b_ready_o) begin
            state_d      = FULL;
            data_d       = b_i;
            sel_d        = SRC_B;
            last_grant_d = SRC_B;
        end else if ((state_q == FULL) && ready_i) begin
            state_d = EMPTY;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= EMPTY;
            data_q       <= '0;
            sel_q        <= SRC_A;
            last_grant_q <= SRC_B;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_o   = data_q;
    assign sel_o   = sel_q;
    assign valid_o = (state_q == FULL);

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: a vector table covering reset, arbitration,
// back-pressure and drain, followed by a sustained-contention throughput sequence.
module tb_mux_arbiter;

    localparam int WIDTH = 16;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [WIDTH-1:0] a_i;
    logic             a_valid_i;
    logic             a_ready_o;
    logic [WIDTH-1:0] b_i;
    logic             b_valid_i;
    logic             b_ready_o;
    logic [WIDTH-1:0] out_o;
    logic             sel_o;
    logic             valid_o;
    logic             ready_i;

    int tests_run = 0;
    int tests_failed = 0;

    mux_arbiter #(.WIDTH(WIDTH)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .a_i       (a_i),
        .a_valid_i (a_valid_i),
        .a_ready_o (a_ready_o),
        .b_i       (b_i),
        .b_valid_i (b_valid_i),
        .b_ready_o (b_ready_o),
        .out_o     (out_o),
        .sel_o     (sel_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i)
    );

    always #5 clk_i = ~clk_i;

    // Inputs applied for one cycle; readies are checked before the edge, register contents after it.
    typedef struct {
        logic             rst;
        logic [WIDTH-1:0] a;
        logic             av;
        logic [WIDTH-1:0] b;
        logic             bv;
        logic             rdy;
        logic             exp_ar;
        logic             exp_br;
        logic             exp_valid;
        logic [WIDTH-1:0] exp_out;
        logic             exp_sel;
    } vec_t;

    localparam int NVEC = 26;
    vec_t vecs [NVEC];

    task automatic check(input string name, input int idx, input logic [31:0] actual,
                         input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, actual, expected);
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge clk_i);
        rst_i     = v.rst;
        a_i       = v.a;
        a_valid_i = v.av;
        b_i       = v.b;
        b_valid_i = v.bv;
        ready_i   = v.rdy;
        #1;
        check("a_ready", idx, 32'(a_ready_o), 32'(v.exp_ar));
        check("b_ready", idx, 32'(b_ready_o), 32'(v.exp_br));
        @(posedge clk_i);
        #1;
        check("valid", idx, 32'(valid_o), 32'(v.exp_valid));
        check("out", idx, 32'(out_o), 32'(v.exp_out));
        check("sel", idx, 32'(sel_o), 32'(v.exp_sel));
    endtask

    function automatic vec_t mk(input logic rst, input logic [WIDTH-1:0] a, input logic av,
                                input logic [WIDTH-1:0] b, input logic bv, input logic rdy,
                                input logic ear, input logic ebr, input logic ev,
                                input logic [WIDTH-1:0] eo, input logic es);
        vec_t v;
        v.rst = rst; v.a = a; v.av = av; v.b = b; v.bv = bv; v.rdy = rdy;
        v.exp_ar = ear; v.exp_br = ebr; v.exp_valid = ev; v.exp_out = eo; v.exp_sel = es;
        return v;
    endfunction

    initial begin
        rst_i = 1'b1; a_i = '0; a_valid_i = 1'b0; b_i = '0; b_valid_i = 1'b0; ready_i = 1'b0;

        //             rst  a         av  b         bv  rdy  ar  br  vld out       sel
        vecs[0]  = mk(1'b1, 16'h1111, 1, 16'h2222, 1, 0,   0,  0,  0,  16'h0000, 0);
        vecs[1]  = mk(1'b1, 16'h1111, 1, 16'h2222, 1, 1,   0,  0,  0,  16'h0000, 0);
        vecs[2]  = mk(1'b0, 16'h1234, 1, 16'h0000, 0, 1,   1,  0,  1,  16'h1234, 0);
        vecs[3]  = mk(1'b0, 16'h0000, 0, 16'h0000, 0, 1,   0,  0,  0,  16'h1234, 0);
        vecs[4]  = mk(1'b0, 16'hAAAA, 1, 16'hBBBB, 1, 1,   0,  1,  1,  16'hBBBB, 1);
        vecs[5]  = mk(1'b0, 16'hAAAA, 1, 16'hBBBB, 1, 1,   1,  0,  1,  16'hAAAA, 0);
        vecs[6]  = mk(1'b0, 16'hAAAA, 1, 16'hBBBB, 1, 1,   0,  1,  1,  16'hBBBB, 1);
        vecs[7]  = mk(1'b0, 16'hAAAA, 1, 16'hBBBB, 1, 1,   1,  0,  1,  16'hAAAA, 0);
        vecs[8]  = mk(1'b0, 16'h0000, 0, 16'h00B1, 1, 1,   0,  1,  1,  16'h00B1, 1);
        vecs[9]  = mk(1'b0, 16'h00A2, 1, 16'h00B2, 1, 0,   0,  0,  1,  16'h00B1, 1);
        vecs[10] = mk(1'b0, 16'h00A2, 1, 16'h00B2, 1, 0,   0,  0,  1,  16'h00B1, 1);
        vecs[11] = mk(1'b0, 16'h00A2, 1, 16'h00B2, 1, 0,   0,  0,  1,  16'h00B1, 1);
        vecs[12] = mk(1'b0, 16'h00A2, 1, 16'h00B2, 1, 1,   1,  0,  1,  16'h00A2, 0);
        vecs[13] = mk(1'b0, 16'h0000, 0, 16'h00B2, 1, 1,   0,  1,  1,  16'h00B2, 1);
        vecs[14] = mk(1'b0, 16'h0000, 0, 16'h0000, 0, 1,   0,  0,  0,  16'h00B2, 1);
        vecs[15] = mk(1'b0, 16'h0000, 0, 16'h0000, 0, 0,   0,  0,  0,  16'h00B2, 1);
        vecs[16] = mk(1'b0, 16'hAAAA, 1, 16'hBBBB, 1, 0,   1,  0,  1,  16'hAAAA, 0);
        vecs[17] = mk(1'b0, 16'h0000, 0, 16'h00B3, 1, 1,   0,  1,  1,  16'h00B3, 1);
        vecs[18] = mk(1'b1, 16'h0000, 0, 16'h0000, 0, 1,   0,  0,  0,  16'h0000, 0);
        vecs[19] = mk(1'b0, 16'h00A3, 1, 16'h0000, 0, 0,   1,  0,  1,  16'h00A3, 0);
        vecs[20] = mk(1'b0, 16'hAAAA, 1, 16'hBBBB, 1, 0,   0,  0,  1,  16'h00A3, 0);
        vecs[21] = mk(1'b1, 16'hAAAA, 1, 16'hBBBB, 1, 1,   0,  0,  0,  16'h0000, 0);
        vecs[22] = mk(1'b0, 16'hAAAA, 1, 16'hBBBB, 1, 1,   1,  0,  1,  16'hAAAA, 0);
        vecs[23] = mk(1'b0, 16'hAAAA, 1, 16'hBBBB, 1, 1,   0,  1,  1,  16'hBBBB, 1);
        vecs[24] = mk(1'b0, 16'h0000, 0, 16'h0000, 0, 0,   0,  0,  1,  16'hBBBB, 1);
        vecs[25] = mk(1'b0, 16'h0000, 0, 16'h0000, 0, 1,   0,  0,  0,  16'hBBBB, 1);

        for (int i = 0; i < NVEC; i++) begin
            apply(i, vecs[i]);
        end

        // Sustained contention from empty with b granted last: one word per cycle, a first, then alternating.
        @(negedge clk_i);
        rst_i = 1'b0; a_i = 16'hC0A0; b_i = 16'hC0B0;
        a_valid_i = 1'b1; b_valid_i = 1'b1; ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic exp_sel;
            exp_sel = k[0];
            #1;
            check("burst_a_ready", 100 + k, 32'(a_ready_o), 32'(!exp_sel));
            check("burst_b_ready", 100 + k, 32'(b_ready_o), 32'(exp_sel));
            @(posedge clk_i);
            #1;
            check("burst_valid", 100 + k, 32'(valid_o), 32'd1);
            check("burst_sel", 100 + k, 32'(sel_o), 32'(exp_sel));
            check("burst_out", 100 + k, 32'(out_o), exp_sel ? 32'h0000C0B0 : 32'h0000C0A0);
            @(negedge clk_i);
        end
        a_valid_i = 1'b0; b_valid_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
